// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: opcodes, inter-stage bundles and the
// memory-stage sequencing states.
package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [2:0]  lc3b_reg;

   typedef enum logic [3:0] {
      op_br   = 4'b0000,
      op_add  = 4'b0001,
      op_ldb  = 4'b0010,
      op_stb  = 4'b0011,
      op_jsr  = 4'b0100,
      op_and  = 4'b0101,
      op_ldr  = 4'b0110,
      op_str  = 4'b0111,
      op_rti  = 4'b1000,
      op_not  = 4'b1001,
      op_ldi  = 4'b1010,
      op_sti  = 4'b1011,
      op_jmp  = 4'b1100,
      op_shf  = 4'b1101,
      op_lea  = 4'b1110,
      op_trap = 4'b1111
   } lc3b_opcode;

   typedef struct packed {
      logic       load_regfile;
      logic       load_cc;
      logic       pc_load;
      logic [1:0] regfile_sel;
   } lc3b_control_word;

   typedef struct packed {
      lc3b_word         intr;
      lc3b_word         pc_out;
      lc3b_word         alu_out;
      lc3b_word         src_data;
      lc3b_reg          destreg;
      lc3b_control_word control_signals;
   } EX_MEM;

   typedef struct packed {
      lc3b_word         intr;
      lc3b_word         pc_out;
      lc3b_word         alu_out;
      lc3b_word         mem_data;
      lc3b_reg          destreg;
      lc3b_control_word control_signals;
   } MEM_WB;

   typedef enum logic {FIRST, SECOND} mem_state_t;

   // A bubble is BR with nzp=000 and no side effects: all-zero bundle.
   localparam EX_MEM BUBBLE_EX_MEM = '0;
   localparam MEM_WB BUBBLE_MEM_WB = '0;

   function automatic lc3b_opcode get_opcode(input lc3b_word intr);
      return lc3b_opcode'(intr[15:12]);
   endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane handling for data memory: load byte select/sign-extend and
// store byte replication with per-lane enables.
module mem_align
   import lc3b_types::*;
(
   input  lc3b_word   rdata,
   input  logic       byte_sel,
   input  logic       is_byte,
   input  lc3b_word   src_data,
   output lc3b_word   load_byte,
   output lc3b_word   store_wdata,
   output logic [1:0] store_be
);

   logic [7:0] sel_byte;

   assign sel_byte  = byte_sel ? rdata[15:8] : rdata[7:0];
   assign load_byte = {{8{sel_byte[7]}}, sel_byte};

   // Lane gi is the low byte for gi=0, high byte for gi=1.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_lane
         assign store_wdata[gi*8 +: 8] = is_byte ? src_data[7:0] : src_data[gi*8 +: 8];
         assign store_be[gi]           = is_byte ? (byte_sel == 1'(gi)) : 1'b1;
      end
   endgenerate

endmodule

// File: rtl/mem_stage.sv
// LC-3b MEM stage: sequences data-cache accesses (including two-access
// LDI/STI), stalls upstream while busy and registers the MEM/WB bundle.
module mem_stage
   import lc3b_types::*;
(
   input  logic       clk,
   input  logic       reset,
   input  EX_MEM      ex_mem,
   input  logic       flush,
   input  logic       dmem_resp,
   input  lc3b_word   dmem_rdata,
   output lc3b_word   dmem_address,
   output logic       dmem_read,
   output logic       dmem_write,
   output lc3b_word   dmem_wdata,
   output logic [1:0] dmem_byte_enable,
   output logic       stall_out,
   output MEM_WB      mem_wb
);

   lc3b_opcode opcode;
   logic       is_mem, is_indirect, is_store, is_byte, is_trap;
   logic       gate_req, squashing, done;

   mem_state_t mem_state_reg, mem_state_next;
   lc3b_word   ptr_reg, ptr_next;
   logic       squash_reg, squash_next;
   logic       req_active_reg, req_active_next;
   MEM_WB      mem_wb_reg, mem_wb_next;

   lc3b_word   load_byte, store_wdata, mem_data;
   logic [1:0] store_be;

   assign opcode      = get_opcode(ex_mem.intr);
   assign is_indirect = (opcode == op_ldi) || (opcode == op_sti);
   assign is_store    = (opcode == op_str) || (opcode == op_stb) || (opcode == op_sti);
   assign is_byte     = (opcode == op_ldb) || (opcode == op_stb);
   assign is_trap     = (opcode == op_trap);
   assign is_mem      = is_indirect || is_store || is_byte || is_trap || (opcode == op_ldr);

   // A flush only suppresses a request the cache has not yet seen.
   assign gate_req  = flush & ~req_active_reg;
   assign squashing = flush | squash_reg;

   mem_align u_align (
      .rdata       (dmem_rdata),
      .byte_sel    (ex_mem.alu_out[0]),
      .is_byte     (is_byte),
      .src_data    (ex_mem.src_data),
      .load_byte   (load_byte),
      .store_wdata (store_wdata),
      .store_be    (store_be)
   );

   // Request generation is kept free of dmem_resp to avoid a loop through the cache.
   always_comb begin
      dmem_address     = '0;
      dmem_read        = 1'b0;
      dmem_write       = 1'b0;
      dmem_wdata       = '0;
      dmem_byte_enable = 2'b00;
      if (!reset) begin
         case (mem_state_reg)
            FIRST: begin
               if (is_mem && !gate_req) begin
                  dmem_address = is_trap ? {7'b0, ex_mem.intr[7:0], 1'b0}
                                         : (ex_mem.alu_out & 16'hFFFE);
                  if (is_store && !is_indirect) begin
                     dmem_write       = 1'b1;
                     dmem_wdata       = store_wdata;
                     dmem_byte_enable = store_be;
                  end else begin
                     dmem_read = 1'b1;
                  end
               end
            end
            SECOND: begin
               dmem_address = ptr_reg & 16'hFFFE;
               if (opcode == op_sti) begin
                  dmem_write       = 1'b1;
                  dmem_wdata       = store_wdata;
                  dmem_byte_enable = store_be;
               end else begin
                  dmem_read = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      mem_state_next  = mem_state_reg;
      ptr_next        = ptr_reg;
      req_active_next = 1'b0;
      done            = 1'b0;
      case (mem_state_reg)
         FIRST: begin
            if (!is_mem || gate_req) begin
               done = 1'b1;
            end else if (dmem_resp) begin
               if (is_indirect && !squashing) begin
                  mem_state_next = SECOND;
                  ptr_next       = dmem_rdata;
               end else begin
                  done = 1'b1;
               end
            end else begin
               req_active_next = 1'b1;
            end
         end
         SECOND: begin
            if (dmem_resp) begin
               done           = 1'b1;
               mem_state_next = FIRST;
            end
         end
         default: mem_state_next = FIRST;
      endcase

      squash_next = done ? 1'b0 : squashing;
      stall_out   = ~done & ~reset;

      case (opcode)
         op_ldb:                  mem_data = load_byte;
         op_ldr, op_ldi, op_trap: mem_data = dmem_rdata;
         default:                 mem_data = ex_mem.alu_out;
      endcase

      mem_wb_next = BUBBLE_MEM_WB;
      if (done && !squashing) begin
         mem_wb_next.intr            = ex_mem.intr;
         mem_wb_next.pc_out          = ex_mem.pc_out;
         mem_wb_next.alu_out         = ex_mem.alu_out;
         mem_wb_next.mem_data        = mem_data;
         mem_wb_next.destreg         = ex_mem.destreg;
         mem_wb_next.control_signals = ex_mem.control_signals;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_state_reg  <= FIRST;
         ptr_reg        <= '0;
         squash_reg     <= 1'b0;
         req_active_reg <= 1'b0;
         mem_wb_reg     <= BUBBLE_MEM_WB;
      end else begin
         mem_state_reg  <= mem_state_next;
         ptr_reg        <= ptr_next;
         squash_reg     <= squash_next;
         req_active_reg <= req_active_next;
         mem_wb_reg     <= mem_wb_next;
      end
   end

   assign mem_wb = mem_wb_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a behavioural data cache of programmable
// response latency.
module tb_mem_stage;
   import lc3b_types::*;

   logic       clk = 1'b0;
   logic       reset;
   EX_MEM      ex_mem;
   logic       flush;
   logic       dmem_resp;
   lc3b_word   dmem_rdata, dmem_address, dmem_wdata;
   logic       dmem_read, dmem_write;
   logic [1:0] dmem_byte_enable;
   logic       stall_out;
   MEM_WB      mem_wb;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk              (clk),
      .reset            (reset),
      .ex_mem           (ex_mem),
      .flush            (flush),
      .dmem_resp        (dmem_resp),
      .dmem_rdata       (dmem_rdata),
      .dmem_address     (dmem_address),
      .dmem_read        (dmem_read),
      .dmem_write       (dmem_write),
      .dmem_wdata       (dmem_wdata),
      .dmem_byte_enable (dmem_byte_enable),
      .stall_out        (stall_out),
      .mem_wb           (mem_wb)
   );

   // Cache model: responds lat cycles after a request first appears.
   logic [15:0] mem [0:32767];
   int          lat = 1;
   int          wait_cnt = 0;
   lc3b_word    read_log[$];

   assign dmem_resp  = (dmem_read | dmem_write) && (wait_cnt >= lat - 1);
   assign dmem_rdata = mem[dmem_address[15:1]];

   always @(posedge clk) begin
      if (reset) begin
         wait_cnt <= 0;
      end else begin
         if ((dmem_read | dmem_write) && !dmem_resp) wait_cnt <= wait_cnt + 1;
         else                                        wait_cnt <= 0;
         if (dmem_resp && dmem_read) read_log.push_back(dmem_address);
         if (dmem_resp && dmem_write) begin
            if (dmem_byte_enable[0]) mem[dmem_address[15:1]][7:0]  <= dmem_wdata[7:0];
            if (dmem_byte_enable[1]) mem[dmem_address[15:1]][15:8] <= dmem_wdata[15:8];
         end
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   lc3b_word   first_addr, first_wdata;
   logic       first_read, first_write;
   logic [1:0] first_be;
   int         stalls, writes;

   // Present op, hold it while stalled, return after the edge that completes it.
   task automatic do_op(input EX_MEM op, input int lat_in, input int flush_cyc);
      logic finished;
      finished = 1'b0;
      lat      = lat_in;
      ex_mem   = op;
      stalls   = 0;
      writes   = 0;
      for (int c = 0; c < 20 && !finished; c++) begin
         flush = (c == flush_cyc);
         @(negedge clk);
         if (c == 0) begin
            first_addr  = dmem_address;
            first_read  = dmem_read;
            first_write = dmem_write;
            first_wdata = dmem_wdata;
            first_be    = dmem_byte_enable;
         end
         if (dmem_write) writes++;
         finished = !stall_out;
         if (!finished) stalls++;
         @(posedge clk);
         #1;
      end
      flush  = 1'b0;
      ex_mem = BUBBLE_EX_MEM;
      check("op_completes", 96'(finished), 96'(1'b1));
   endtask

   function automatic EX_MEM mk(input lc3b_word intr, input lc3b_word alu, input lc3b_word src);
      EX_MEM e;
      e.intr            = intr;
      e.pc_out          = 16'h1000;
      e.alu_out         = alu;
      e.src_data        = src;
      e.destreg         = intr[11:9];
      e.control_signals = lc3b_control_word'(5'b11011);
      return e;
   endfunction

   function automatic MEM_WB exp_wb(input EX_MEM e, input lc3b_word data);
      MEM_WB w;
      w.intr            = e.intr;
      w.pc_out          = e.pc_out;
      w.alu_out         = e.alu_out;
      w.mem_data        = data;
      w.destreg         = e.destreg;
      w.control_signals = e.control_signals;
      return w;
   endfunction

   EX_MEM op;

   initial begin
      for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
      mem[16'h3002 >> 1] = 16'hBEEF;
      mem[16'h0100 >> 1] = 16'h8012;
      mem[16'h0040 >> 1] = 16'h5000;
      mem[16'h5000 >> 1] = 16'h00AA;
      mem[16'h004A >> 1] = 16'h1200;
      mem[16'h0042 >> 1] = 16'h6000;

      // Reset with a load presented: no request may leak out.
      reset  = 1'b1;
      flush  = 1'b0;
      ex_mem = mk(16'h6240, 16'h3003, 16'h0000);
      @(posedge clk); #1;
      @(negedge clk);
      check("reset_read", 96'(dmem_read), 96'(1'b0));
      check("reset_write", 96'(dmem_write), 96'(1'b0));
      check("reset_stall", 96'(stall_out), 96'(1'b0));
      check("reset_be", 96'(dmem_byte_enable), 96'(2'b00));
      check("reset_wb", 96'(mem_wb), 96'(BUBBLE_MEM_WB));
      @(posedge clk); #1;
      ex_mem = BUBBLE_EX_MEM;
      reset  = 1'b0;

      // LDR r1, 3-cycle cache
      op = mk(16'h6240, 16'h3003, 16'h0000);
      do_op(op, 3, -1);
      check("ldr_addr", 96'(first_addr), 96'(16'h3002));
      check("ldr_read", 96'(first_read), 96'(1'b1));
      check("ldr_stalls", 96'(stalls), 96'(2));
      check("ldr_wb", 96'(mem_wb), 96'(exp_wb(op, 16'hBEEF)));
      $display("LDR  addr=%h stalls=%0d mem_data=%h", first_addr, stalls, mem_wb.mem_data);

      // LDB high byte, sign-extended
      op = mk(16'h2200, 16'h0101, 16'h0000);
      do_op(op, 1, -1);
      check("ldb_addr", 96'(first_addr), 96'(16'h0100));
      check("ldb_stalls", 96'(stalls), 96'(0));
      check("ldb_wb", 96'(mem_wb), 96'(exp_wb(op, 16'hFF80)));
      $display("LDB  addr=%h mem_data=%h", first_addr, mem_wb.mem_data);

      // STB low byte
      op = mk(16'h3200, 16'h0100, 16'h1234);
      do_op(op, 1, -1);
      check("stb_write", 96'(first_write), 96'(1'b1));
      check("stb_wdata", 96'(first_wdata), 96'(16'h3434));
      check("stb_be", 96'(first_be), 96'(2'b01));
      check("stb_mem", 96'(mem[16'h0100 >> 1]), 96'(16'h8034));
      check("stb_intr", 96'(mem_wb.intr), 96'(16'h3200));
      $display("STB  wdata=%h be=%b", first_wdata, first_be);

      // LDI through pointer
      read_log.delete();
      op = mk(16'hA200, 16'h0040, 16'h0000);
      do_op(op, 1, -1);
      check("ldi_nreads", 96'(read_log.size()), 96'(2));
      if (read_log.size() == 2) begin
         check("ldi_read0", 96'(read_log[0]), 96'(16'h0040));
         check("ldi_read1", 96'(read_log[1]), 96'(16'h5000));
      end
      check("ldi_stalls", 96'(stalls), 96'(1));
      check("ldi_wb", 96'(mem_wb), 96'(exp_wb(op, 16'h00AA)));
      $display("LDI  stalls=%0d mem_data=%h", stalls, mem_wb.mem_data);

      // STI through pointer at 0x0042 -> 0x6000
      op = mk(16'hB200, 16'h0042, 16'h7777);
      do_op(op, 1, -1);
      check("sti_writes", 96'(writes), 96'(1));
      check("sti_mem", 96'(mem[16'h6000 >> 1]), 96'(16'h7777));
      check("sti_ptr_kept", 96'(mem[16'h0042 >> 1]), 96'(16'h6000));
      $display("STI  writes=%0d mem[6000]=%h", writes, mem[16'h6000 >> 1]);

      // STR squashed on arrival
      op = mk(16'h7200, 16'h2000, 16'h5555);
      do_op(op, 1, 0);
      check("strfl_writes", 96'(writes), 96'(0));
      check("strfl_mem", 96'(mem[16'h2000 >> 1]), 96'(16'h0000));
      check("strfl_wb", 96'(mem_wb), 96'(BUBBLE_MEM_WB));
      $display("STR+flush writes=%0d", writes);

      // Flush while a read is in flight: held to completion, then bubble
      op = mk(16'h6240, 16'h3002, 16'h0000);
      do_op(op, 3, 1);
      check("ldrfl_read", 96'(first_read), 96'(1'b1));
      check("ldrfl_stalls", 96'(stalls), 96'(2));
      check("ldrfl_wb", 96'(mem_wb), 96'(BUBBLE_MEM_WB));
      $display("LDR+flush stalls=%0d", stalls);

      // TRAP x25
      op = mk(16'hF025, 16'h0000, 16'h0000);
      do_op(op, 1, -1);
      check("trap_addr", 96'(first_addr), 96'(16'h004A));
      check("trap_wb", 96'(mem_wb), 96'(exp_wb(op, 16'h1200)));
      $display("TRAP addr=%h vector=%h", first_addr, mem_wb.mem_data);

      // BR: no memory traffic
      op = mk(16'h0E05, 16'h0200, 16'h0000);
      do_op(op, 1, -1);
      check("br_read", 96'(first_read), 96'(1'b0));
      check("br_write", 96'(first_write), 96'(1'b0));
      check("br_stalls", 96'(stalls), 96'(0));
      check("br_wb", 96'(mem_wb), 96'(exp_wb(op, 16'h0200)));
      $display("BR   mem_data=%h", mem_wb.mem_data);

      // Reset during the second LDI access
      lat    = 1;
      ex_mem = mk(16'hA200, 16'h0040, 16'h0000);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("rstldi_read", 96'(dmem_read), 96'(1'b0));
      check("rstldi_stall", 96'(stall_out), 96'(1'b0));
      @(posedge clk); #1;
      reset  = 1'b0;
      ex_mem = BUBBLE_EX_MEM;
      check("rstldi_state", 96'(dut.mem_state_reg), 96'(FIRST));
      check("rstldi_wb", 96'(mem_wb), 96'(BUBBLE_MEM_WB));
      $display("RST mid-LDI state=%0d", dut.mem_state_reg);

      // Pipeline recovers with a fresh LDR
      op = mk(16'h6240, 16'h3003, 16'h0000);
      do_op(op, 1, -1);
      check("post_rst_wb", 96'(mem_wb), 96'(exp_wb(op, 16'hBEEF)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Fourth stage of the LC-3b pipeline, between the execute stage and `wb_stage`. It takes the EX/MEM bundle, performs all data-memory traffic through the data-cache handshake, and registers the MEM/WB bundle consumed by writeback. Memory traffic covers LDR/STR, LDB/STB, the two-access LDI/STI, and the TRAP vector read. It stalls upstream while the cache is busy, inserts bubbles downstream, and squashes its instruction on a writeback flush.

## Interface
Parameters:
- none; widths come from `lc3b_types` (`lc3b_word` = 16 b).

Ports:
- `clk`  in  1  pipeline clock
- `reset`  in  1  synchronous, active-high reset
- `ex_mem`  in  EX_MEM  instruction bundle: `intr`, `pc_out`, `alu_out` (effective address or computed target), `src_data` (store data), `destreg`, `control_signals`
- `flush`  in  1  squash the instruction currently in this stage (from writeback)
- `dmem_resp`  in  1  cache completes the current request this cycle
- `dmem_rdata`  in  16  cache read data, valid with `dmem_resp`
- `dmem_address`  out  16  word-aligned request address (bit 0 = 0)
- `dmem_read`  out  1  read request, held until `dmem_resp`
- `dmem_write`  out  1  write request, held until `dmem_resp`
- `dmem_wdata`  out  16  write data
- `dmem_byte_enable`  out  2  write lanes; `[1]` = high byte
- `stall_out`  out  1  hold IF/ID/EX and the EX/MEM register
- `mem_wb`  out  MEM_WB  registered bundle to writeback

## Operation
- Bubble: `intr`=16'h0000 (BR with nzp=000), all `control_signals` zero, other fields zero.
- Non-memory op (not LDR/LDB/LDI/STR/STB/STI/TRAP):
  - no request is issued;
  - `mem_data` = `ex_mem.alu_out`, which writeback uses as the branch/JMP/JSR target;
  - completes in one cycle.
- LDR/STR:
  - one access at `alu_out & 16'hFFFE`;
  - STR writes `src_data` with byte enable 2'b11.
- LDB: read the word; select the byte by `alu_out[0]` (1 = high byte); sign-extend to 16 b into `mem_data`.
- STB: `dmem_wdata` = {`src_data[7:0]`, `src_data[7:0]`}; byte enable 2'b10 if `alu_out[0]`, else 2'b01.
- LDI/STI:
  - first read at `alu_out`; capture `dmem_rdata` in pointer register `ptr`;
  - second access at `ptr & 16'hFFFE`: read for LDI (result into `mem_data`), word write of `src_data` for STI.
- TRAP:
  - one read at {7'b0, `intr[7:0]`, 1'b0};
  - `mem_data` = vector, which writeback uses as `new_pc`.
- FSM `mem_state`:
  - FIRST (reset): requests are driven combinationally from `ex_mem`. On `dmem_resp`, LDI/STI go to SECOND; all other ops complete.
  - SECOND: requests are driven from `ptr`. On `dmem_resp`, complete and go to FIRST.
- Flush:
  - FIRST, before any `dmem_resp`: requests are gated off by `~flush`, so a squashed store never writes. The `squash` flag is set, and a bubble is loaded when the instruction leaves.
  - Mid-read (in SECOND, or FIRST after a request was accepted): keep the request until `dmem_resp`, discard the data, load a bubble, return to FIRST.
- Passthrough on complete: `intr`, `pc_out`, `alu_out`, `destreg`, `control_signals` are copied to `mem_wb`.

## Timing
- Reset:
  - `mem_state`=FIRST; `ptr`=0; `squash`=0;
  - `mem_wb` = bubble;
  - `dmem_read`/`dmem_write`/`stall_out`=0; `dmem_byte_enable`=0.
- `stall_out` = memory op pending and not completing this cycle. It is combinational and deasserts in the cycle `dmem_resp` completes the op.
- `mem_wb` loads at the edge after completion.
- While `stall_out`=1, `mem_wb` loads a bubble each edge, so writeback never re-executes.
- Best-case latency: a single-access op with `dmem_resp` in its first cycle takes 1 cycle, with no stall.
- Slower paths: LDI/STI take at least 2 cycles. An N-cycle cache adds N−1 stall cycles per access.
- `dmem_address`/`dmem_wdata`/`dmem_byte_enable` are stable while a request is held.
- Reset mid-access drops the request immediately; the cache is reset by the same signal.

## Structure
- `lc3b_types` holds:
  - `EX_MEM` and `MEM_WB` structs, including `src_data` in EX_MEM;
  - the opcode enum;
  - the `mem_state_t` enum {FIRST, SECOND};
  - the bubble constant.
- One sub-module, `mem_align`, which is purely combinational:
  - load byte select and sign-extend;
  - store byte replication and byte-enable generation.

## Test plan
- LDR r1 at `alu_out`=16'h3003, mem[16'h3002]=16'hBEEF, resp after 3 cycles:
  - address 16'h3002;
  - 2 stall cycles;
  - `mem_data`=16'hBEEF.
- LDB at 16'h0101, mem[16'h0100]=16'h8012: `mem_data`=16'hFF80.
- STB at 16'h0100 with `src_data`=16'h1234: `dmem_wdata`=16'h3434, byte enable 2'b01.
- LDI at 16'h0040, mem[16'h0040]=16'h5000, mem[16'h5000]=16'h00AA, single-cycle resp:
  - two reads, 16'h0040 then 16'h5000;
  - 1 stall cycle;
  - `mem_data`=16'h00AA.
- STR arriving with `flush`=1: `dmem_write` never asserts and `mem_wb` = bubble.
- TRAP x25: reads 16'h004A; `mem_data` = vector. BR x with `alu_out`=16'h0200: `mem_data`=16'h0200 with no request. Reset mid-LDI gives the bubble and FIRST.
